// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// default stall-timeout limit and a constant-friendly ceil(log2) helper.
package fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Usable in parameter/localparam expressions; returns at least 1 so that
  // index vectors never collapse to zero width.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    if (width == 0) begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the one-hot first requester
// strictly after rr_last (wrapping at NREQ-1), or zero when nobody requests.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_last,
  output logic [NREQ-1:0] grant
);

  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [IDXW-1:0] last);
    logic [NREQ-1:0] result;
    logic found;
    int idx;
    result = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && r[idx]) begin
        result[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return result;
  endfunction

  assign grant = pick(req, rr_last);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin scheduler for the async FIFO write port (wclk domain).
// Optional stall timeout that force-releases an idle grant: define WR_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  input  logic [NREQ-1:0]          req_last_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic                     wfull_i,
  output logic                     wincr_o,
  output logic [DATA_W-1:0]        wdata_o,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int IDXW = clog2(NREQ);

  state_t          state;
  logic [IDXW-1:0] rr_last;
  logic [IDXW-1:0] grant_idx;
  logic [NREQ-1:0] next_grant;
  logic            accept;
  logic            last_beat;
  logic            timeout_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req     (req_valid_i),
    .rr_last (rr_last),
    .grant   (next_grant)
  );

  // grant_o is zero outside LOCK, so ready/wincr/wdata all vanish when idle.
  assign req_ready_o = grant_o & {NREQ{~wfull_i}};
  assign accept      = |(req_valid_i & req_ready_o);
  assign last_beat   = |(req_valid_i & req_ready_o & req_last_i);
  assign wincr_o     = accept;

  always_comb begin
    wdata_o   = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_o[i]) begin
        wdata_o   = req_data_i[i*DATA_W +: DATA_W];
        grant_idx = IDXW'(i);
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state   <= ST_IDLE;
      grant_o <= '0;
      busy_o  <= 1'b0;
      rr_last <= IDXW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid_i) begin
            grant_o <= next_grant;
            busy_o  <= 1'b1;
            state   <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (last_beat || timeout_hit) begin
            rr_last <= grant_idx;
            grant_o <= '0;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          grant_o <= '0;
          busy_o  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WR_ARB_TIMEOUT_EN
  localparam int CNTW = clog2(TIMEOUT) + 1;

  logic [CNTW-1:0] idle_cnt;
  logic            idle_inc;

  // Only a silent granted requester counts; a full FIFO is not its fault.
  assign idle_inc    = ~(|(req_valid_i & grant_o)) & ~wfull_i;
  assign timeout_hit = (state == ST_LOCK) && !accept && idle_inc &&
                       (idle_cnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      if (state != ST_LOCK || accept || timeout_hit) begin
        idle_cnt <= '0;
      end else if (idle_inc) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule
